// File: rtl/decay_pkg.sv
// Shared definitions for the potential decay engine: rate codes, FSM states, FP field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decay_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [3:0] RATE_DIV1 = 4'b0001;
    localparam logic [3:0] RATE_DIV2 = 4'b0010;
    localparam logic [3:0] RATE_DIV4 = 4'b0100;
    localparam logic [3:0] RATE_DIV8 = 4'b1000;
    localparam logic [3:0] RATE_3Q   = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fp_decay_unit.sv
// Combinational IEEE-754 single decay: divide by 1/2/4/8 via exponent, optional 0.75x (DECAY_THREE_QUARTER_EN).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module fp_decay_unit
    import decay_pkg::*;
(
    input  logic [31:0] potential_i,
    input  logic [3:0]  rate_i,
    output logic [31:0] potential_o
);

    logic             sign;
    logic [EXP_W-1:0] exp_in;
    logic [MAN_W-1:0] man_in;
    logic [EXP_W-1:0] shift_k;
    logic [EXP_W-1:0] exp_div;

    assign sign    = potential_i[31];
    assign exp_in  = potential_i[30:23];
    assign man_in  = potential_i[22:0];
    assign exp_div = exp_in - shift_k;

`ifdef DECAY_THREE_QUARTER_EN
    // 3 * {1,mantissa} as x + 2x; 26 bits hold the full product.
    logic [25:0]      prod;
    logic [EXP_W-1:0] exp_dec;
    assign prod    = {2'b00, 1'b1, man_in} + {1'b0, 1'b1, man_in, 1'b0};
    assign exp_dec = exp_in - 8'd1;
`endif

    // Map the rate code to an exponent decrement; unknown codes mean no decay.
    always_comb begin
        shift_k = 8'd0;
        case (rate_i)
            RATE_DIV2: shift_k = 8'd1;
            RATE_DIV4: shift_k = 8'd2;
            RATE_DIV8: shift_k = 8'd3;
            default:   shift_k = 8'd0;
        endcase
    end

    // Special values first (Inf/NaN pass, zero/denormal -> signed zero), then the decay itself.
    always_comb begin
        potential_o = potential_i;
        if (exp_in == 8'hFF) begin
            potential_o = potential_i;
        end else if (exp_in == 8'h00) begin
            potential_o = {sign, 31'b0};
`ifdef DECAY_THREE_QUARTER_EN
        end else if (rate_i == RATE_3Q) begin
            // Product >= 2.0 keeps the exponent; otherwise renormalise down by one.
            if (prod[25]) begin
                potential_o = {sign, exp_in, prod[24:2]};
            end else if (exp_in == 8'd1) begin
                potential_o = {sign, 31'b0};
            end else begin
                potential_o = {sign, exp_dec, prod[23:1]};
            end
`endif
        end else if (shift_k != 8'd0) begin
            if (exp_in <= shift_k) begin
                potential_o = {sign, 31'b0};
            end else begin
                potential_o = {sign, exp_div, man_in};
            end
        end
    end

endmodule

// File: rtl/potential_decay_engine.sv
// Neuron potential store with a timestep-triggered decay sweep (one neuron per cycle, optional DECAY_THREE_QUARTER_EN).
// Latency: 1 clock from neuron issue to out_*; sweep takes NEURONS+1 cycles from timestep to done.
// Backpressure: wr_ready low outside IDLE, writes are dropped; timestep while busy is ignored and sets overrun.
module potential_decay_engine
    import decay_pkg::*;
#(
    parameter int         NEURONS      = 16,
    parameter int         ADDR_W       = $clog2(NEURONS),
    parameter logic [3:0] DEFAULT_RATE = 4'b0010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_valid,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_potential,
    input  logic [3:0]        init_rate,
    input  logic              acc_valid,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [31:0]       acc_potential,
    output logic              wr_ready,
    input  logic              timestep,
    output logic              busy,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              done,
    output logic              overrun
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       pot_q  [NEURONS];
    logic [3:0]        rate_q [NEURONS];
    logic              out_valid_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [31:0]       out_pot_q;
    logic              overrun_q;
    logic [31:0]       dec_pot;
    logic              last_idx;

    assign last_idx = (idx_q == ADDR_W'(NEURONS - 1));

    fp_decay_unit u_decay (
        .potential_i (pot_q[idx_q]),
        .rate_i      (rate_q[idx_q]),
        .potential_o (dec_pot)
    );

    // State and sweep index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: start on timestep, walk all neurons, one DONE cycle, back to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (timestep) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                idx_d = idx_q + ADDR_W'(1);
                if (last_idx) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Potential/rate storage: external writes only in IDLE (init wins a collision), decay write-back in SWEEP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURONS; i++) begin
                pot_q[i]  <= 32'h0;
                rate_q[i] <= DEFAULT_RATE;
            end
        end else if (state_q == SWEEP) begin
            pot_q[idx_q] <= dec_pot;
        end else if (state_q == IDLE) begin
            if (acc_valid) begin
                pot_q[acc_addr] <= acc_potential;
            end
            if (init_valid) begin
                pot_q[init_addr]  <= init_potential;
                rate_q[init_addr] <= init_rate;
            end
        end
    end

    // Output register for the decayed value, plus the sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_pot_q   <= 32'h0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= (state_q == SWEEP);
            if (state_q == SWEEP) begin
                out_addr_q <= idx_q;
                out_pot_q  <= dec_pot;
            end
            if (timestep && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign wr_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign out_valid     = out_valid_q;
    assign out_addr      = out_addr_q;
    assign out_potential = out_pot_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_potential_decay_engine.sv
// Self-checking bench for potential_decay_engine: behavioural sweep model plus directed literal vectors.
// Latency: checks outputs every cycle at the falling edge.
// Backpressure: exercises dropped writes, overrun and mid-sweep reset.
module tb_potential_decay_engine;

    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_valid = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [31:0]   init_potential = '0;
    logic [3:0]    init_rate = '0;
    logic          acc_valid = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [31:0]   acc_potential = '0;
    logic          wr_ready;
    logic          timestep = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_potential;
    logic          done;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    potential_decay_engine #(.NEURONS(N), .ADDR_W(AW), .DEFAULT_RATE(4'b0010)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_valid     (init_valid),
        .init_addr      (init_addr),
        .init_potential (init_potential),
        .init_rate      (init_rate),
        .acc_valid      (acc_valid),
        .acc_addr       (acc_addr),
        .acc_potential  (acc_potential),
        .wr_ready       (wr_ready),
        .timestep       (timestep),
        .busy           (busy),
        .out_valid      (out_valid),
        .out_addr       (out_addr),
        .out_potential  (out_potential),
        .done           (done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decay rule in float-field arithmetic: exponent shift, or 3*(1.m) renormalised.
    function automatic logic [31:0] model_decay(input logic [31:0] x, input logic [3:0] r);
        int   e;
        int   k;
        int   p;
        logic s;
        s = x[31];
        e = int'(x[30:23]);
        k = 0;
        p = 0;
        if (e == 255) return x;
        if (e == 0) return {s, 31'b0};
`ifdef DECAY_THREE_QUARTER_EN
        if (r == 4'b0011) begin
            p = 3 * int'({1'b1, x[22:0]});
            if (p >= (1 << 25)) begin
                p = p >> 2;
            end else begin
                p = p >> 1;
                e = e - 1;
            end
            if (e <= 0) return {s, 31'b0};
            return {s, 8'(e), 23'(p)};
        end
`endif
        case (r)
            4'b0010: k = 1;
            4'b0100: k = 2;
            4'b1000: k = 3;
            default: k = 0;
        endcase
        if (e - k <= 0) return {s, 31'b0};
        return {s, 8'(e - k), x[22:0]};
    endfunction

    // Model state: contents, decayed snapshot of the current sweep, cycles since sweep start.
    logic [31:0] pot_m  [N];
    logic [3:0]  rate_m [N];
    logic [31:0] dec_m  [N];
    int          c = 0;
    bit          ov_m = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pot_m[i]  = 32'h0;
                rate_m[i] = 4'b0010;
                dec_m[i]  = 32'h0;
            end
            c    = 0;
            ov_m = 1'b0;
        end else if (c == 0) begin
            if (acc_valid) pot_m[acc_addr] = acc_potential;
            if (init_valid) begin
                pot_m[init_addr]  = init_potential;
                rate_m[init_addr] = init_rate;
            end
            if (timestep) begin
                for (int i = 0; i < N; i++) begin
                    dec_m[i] = model_decay(pot_m[i], rate_m[i]);
                    pot_m[i] = dec_m[i];
                end
                c = 1;
            end
        end else begin
            if (timestep) ov_m = 1'b1;
            c = (c == N + 1) ? 0 : c + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, c != 0);
            chk("wr_ready", wr_ready, c == 0);
            chk("out_valid", out_valid, c >= 2);
            chk("done", done, c == N + 1);
            chk("overrun", overrun, ov_m);
            if (c >= 2) begin
                chk("out_addr", out_addr, c - 2);
                chk("out_potential", out_potential, dec_m[c - 2]);
            end
        end
    end

    logic [31:0] cap [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse timestep, collect every out_* value, return the cycle done appears on; ends in IDLE.
    task automatic sweep(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < N; i++) cap[i] = 32'hDEADBEEF;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        for (int k = 1; k <= 3 * N; k++) begin
            if (out_valid) cap[out_addr] = out_potential;
            if (done) begin
                dcyc = k;
                break;
            end
            tick();
        end
        if (dcyc < 0) chk("sweep_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic write_init(input int a, input logic [31:0] v, input logic [3:0] r);
        init_valid = 1'b1; init_addr = AW'(a); init_potential = v; init_rate = r;
        tick();
        init_valid = 1'b0;
    endtask

    task automatic vec(input string name, input logic [31:0] v, input logic [3:0] r, input logic [31:0] exp);
        int d;
        chk({"model_", name}, model_decay(v, r), exp);
        write_init(0, v, r);
        sweep(d);
        chk(name, cap[0], exp);
    endtask

    int d;
    int nz;
    logic [31:0] exp3q;

    initial begin
        repeat (3) tick();
        chk_en = 1'b1;
        #4;
        // Reset-state literals.
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_out_pot", out_potential, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic decay and sweep length.
        write_init(0, 32'h41DEB852, 4'b0010);
        sweep(d);
        chk("basic_pot", cap[0], 32'h415EB852);
        chk("done_cycle", d, N + 1);

        // Rate codes.
        vec("rate4", 32'h41DEB852, 4'b0100, 32'h40DEB852);
        vec("rate8", 32'h41DEB852, 4'b1000, 32'h405EB852);
`ifdef DECAY_THREE_QUARTER_EN
        exp3q = 32'h41A70A3D;
`else
        exp3q = 32'h41DEB852;
`endif
        vec("rate3q", 32'h41DEB852, 4'b0011, exp3q);
        vec("rate_undef", 32'h41DEB852, 4'b0111, 32'h41DEB852);
        vec("rate1", 32'h41DEB852, 4'b0001, 32'h41DEB852);

        // Special values and flush boundaries.
        vec("min_norm", 32'h00800000, 4'b0010, 32'h00000000);
        vec("neg", 32'hC1DEB852, 4'b0010, 32'hC15EB852);
        vec("inf", 32'h7F800000, 4'b1000, 32'h7F800000);
        vec("nan", 32'hFFC00001, 4'b0010, 32'hFFC00001);
        vec("denorm", 32'h80000005, 4'b0001, 32'h80000000);
        vec("exp2_div2", 32'h01000000, 4'b0010, 32'h00800000);
        vec("exp3_div8", 32'h81800000, 4'b1000, 32'h80000000);

        // Init/acc collision on one address, then on different addresses.
        init_valid = 1'b1; init_addr = 4'd5; init_potential = 32'h3F800000; init_rate = 4'b0001;
        acc_valid  = 1'b1; acc_addr  = 4'd5; acc_potential  = 32'h40400000;
        tick();
        init_addr = 4'd7; init_potential = 32'h12345678;
        acc_addr  = 4'd8; acc_potential  = 32'h40000000;
        tick();
        init_valid = 1'b0; acc_valid = 1'b0;
        sweep(d);
        chk("same_addr_init_wins", cap[5], 32'h3F800000);
        chk("diff_addr_init", cap[7], 32'h12345678);
        chk("diff_addr_acc", cap[8], 32'h3F800000);

        // Write during a sweep is dropped; the same write afterwards lands.
        write_init(3, 32'h40800000, 4'b0010);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        tick();
        chk("mid_sweep_wr_ready", wr_ready, 1'b0);
        acc_valid = 1'b1; acc_addr = 4'd3; acc_potential = 32'h41DEB852;
        tick();
        acc_valid = 1'b0;
        for (int k = 0; k < 3 * N && !done; k++) tick();
        chk("blocked_done_seen", done, 1'b1);
        tick();
        acc_valid = 1'b1; acc_addr = 4'd3; acc_potential = 32'h41DEB852;
        tick();
        acc_valid = 1'b0;
        sweep(d);
        chk("acc_after_done", cap[3], 32'h415EB852);

        // Overrun: a second timestep mid-sweep neither restarts nor stretches the sweep.
        chk("overrun_before", overrun, 1'b0);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        d = -1;
        for (int k = 1; k <= 3 * N; k++) begin
            if (done) begin
                d = k;
                break;
            end
            timestep = (k == 4);
            tick();
        end
        timestep = 1'b0;
        chk("overrun_done_cycle", d, N + 1);
        tick();
        chk("overrun_sticky", overrun, 1'b1);

        // Reset mid-sweep: outputs clear immediately, no done, next sweep yields zeros.
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_overrun", overrun, 1'b0);
        chk("mid_rst_out_addr", out_addr, 32'd0);
        chk("mid_rst_out_pot", out_potential, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        sweep(d);
        nz = 0;
        for (int i = 0; i < N; i++) if (cap[i] !== 32'h0) nz++;
        chk("post_reset_nonzero", nz, 0);
        chk("post_reset_done_cycle", d, N + 1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
